// File: rtl/pipo_load_arbiter.sv
// Purpose: 3-way round-robin arbiter that loads the winner's 4-bit word into a shared PIPO register.
// Latency: grant registered one edge after request; q/owner update at the edge ending the LOAD cycle.
// Backpressure: none; requests are ignored while busy, and every transaction ends with at least one IDLE cycle.
module pipo_load_arbiter #(
    parameter int HOLD_CYC = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    output logic [2:0] gnt,
    output logic [3:0] q,
    output logic [1:0] owner,
    output logic       busy,
    output logic       load_pulse
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Counter value on entry to HOLD; counts down to zero, giving HOLD_CYC cycles in HOLD.
    localparam logic [3:0] HOLD_LAST = (HOLD_CYC > 0) ? 4'(HOLD_CYC - 1) : 4'd0;

    state_t     state_q, state_d;
    logic [2:0] gnt_q, gnt_d;
    logic [3:0] q_q, q_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] cnt_q, cnt_d;

    logic       win_vld;
    logic [1:0] win_idx;
    logic [3:0] win_dat;

    // Round-robin search starting one past the last winner, wrapping 2 -> 0.
    always_comb begin
        logic [1:0] idx;
        win_vld = 1'b0;
        win_idx = ptr_q;
        idx     = ptr_q;
        for (int k = 0; k < 3; k++) begin
            idx = (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win_idx = idx;
            end
        end
    end

    // Data of the current transaction's owner; the pointer holds the winner during LOAD.
    always_comb begin
        case (ptr_q)
            2'd0:    win_dat = d0;
            2'd1:    win_dat = d1;
            default: win_dat = d2;
        endcase
    end

    // Next-state logic for the IDLE -> LOAD -> HOLD -> IDLE transaction sequence.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        q_d     = q_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                gnt_d = 3'b000;
                if (win_vld) begin
                    state_d = LOAD;
                    gnt_d   = 3'b001 << win_idx;
                    ptr_d   = win_idx;
                end
            end
            LOAD: begin
                q_d     = win_dat;
                owner_d = ptr_q;
                if (HOLD_CYC > 0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LAST;
                end else begin
                    state_d = IDLE;
                    gnt_d   = 3'b000;
                end
            end
            HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    gnt_d   = 3'b000;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 3'b000;
            end
        endcase
    end

    // State registers; reset leaves the pointer at 2 so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= 3'b000;
            q_q     <= 4'b0000;
            owner_q <= 2'd0;
            ptr_q   <= 2'd2;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            q_q     <= q_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt        = gnt_q;
    assign q          = q_q;
    assign owner      = owner_q;
    assign busy       = (state_q != IDLE);
    assign load_pulse = (state_q == LOAD);

endmodule

// File: tb/tb_pipo_load_arbiter.sv
module tb_pipo_load_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] req;
    logic [3:0] d0, d1, d2;

    logic [2:0] gnt_a, gnt_b;
    logic [3:0] q_a, q_b;
    logic [1:0] owner_a, owner_b;
    logic       busy_a, busy_b, lp_a, lp_b;

    int pass_cnt = 0;
    int fail_cnt = 0;

    typedef struct {
        string      tag;
        bit         sel;   // 0: default-HOLD DUT, 1: HOLD_CYC=0 DUT
        logic [2:0] gnt;
        logic [3:0] q;
        logic [1:0] owner;
        logic       busy;
        logic       lp;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pipo_load_arbiter #(.HOLD_CYC(2)) dut (
        .clk(clk), .reset(reset), .req(req), .d0(d0), .d1(d1), .d2(d2),
        .gnt(gnt_a), .q(q_a), .owner(owner_a), .busy(busy_a), .load_pulse(lp_a)
    );

    pipo_load_arbiter #(.HOLD_CYC(0)) dut0 (
        .clk(clk), .reset(reset), .req(req), .d0(d0), .d1(d1), .d2(d2),
        .gnt(gnt_b), .q(q_b), .owner(owner_b), .busy(busy_b), .load_pulse(lp_b)
    );

    task automatic expect_out(input string tag, input bit sel, input logic [2:0] g,
                              input logic [3:0] qq, input logic [1:0] o,
                              input logic b, input logic l);
        exp_t e;
        e.tag = tag; e.sel = sel; e.gnt = g; e.q = qq; e.owner = o; e.busy = b; e.lp = l;
        sb.push_back(e);
    endtask

    // Advance one clock, then sample 1 time unit after the edge and check the oldest expectation.
    task automatic step();
        exp_t       e;
        logic [13:0] obs, exv;
        logic [2:0]  g;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            $display("FAIL scoreboard_empty observed=0 entries required=1 entry");
            fail_cnt++;
            $fatal(1, "scoreboard underflow");
        end
        e = sb.pop_front();
        if (e.sel) begin
            obs = {gnt_b, q_b, owner_b, busy_b, lp_b};
            g   = gnt_b;
        end else begin
            obs = {gnt_a, q_a, owner_a, busy_a, lp_a};
            g   = gnt_a;
        end
        exv = {e.gnt, e.q, e.owner, e.busy, e.lp};
        assert (obs === exv) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s observed gnt=%b q=%b owner=%0d busy=%b lp=%b required gnt=%b q=%b owner=%0d busy=%b lp=%b",
                   e.tag, obs[13:11], obs[10:7], obs[6:5], obs[4], obs[3],
                   e.gnt, e.q, e.owner, e.busy, e.lp);
        end
        assert ($countones(g) <= 1) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s_onehot observed gnt=%b required at most one bit set", e.tag, g);
        end
    endtask

    initial begin
        logic [3:0] dv [3];
        logic [3:0] prev_q;
        logic [1:0] prev_o;
        logic [2:0] w;

        // Reset held two cycles with all requests pending.
        reset = 1'b1; req = 3'b111; d0 = 4'b1010; d1 = 4'b0000; d2 = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            expect_out("reset", 0, 3'b000, 4'b0000, 2'd0, 1'b0, 1'b0);
            step();
        end

        // Single request from requester 1.
        reset = 1'b0; req = 3'b010; d1 = 4'b0110;
        expect_out("single_load", 0, 3'b010, 4'b0000, 2'd0, 1'b1, 1'b1);
        step();
        req = 3'b000;
        expect_out("single_hold1", 0, 3'b010, 4'b0110, 2'd1, 1'b1, 1'b0);
        step();
        expect_out("single_hold2", 0, 3'b010, 4'b0110, 2'd1, 1'b1, 1'b0);
        step();
        expect_out("single_idle", 0, 3'b000, 4'b0110, 2'd1, 1'b0, 1'b0);
        step();
        expect_out("single_idle2", 0, 3'b000, 4'b0110, 2'd1, 1'b0, 1'b0);
        step();

        // Reset again so requester 0 has first priority, then all request.
        reset = 1'b1;
        expect_out("rr_reset", 0, 3'b000, 4'b0000, 2'd0, 1'b0, 1'b0);
        step();
        reset = 1'b0; req = 3'b111; d0 = 4'b0001; d1 = 4'b0010; d2 = 4'b0100;
        dv[0] = 4'b0001; dv[1] = 4'b0010; dv[2] = 4'b0100;
        prev_q = 4'b0000; prev_o = 2'd0;
        for (int k = 0; k < 4; k++) begin
            w = 3'b001 << (k % 3);
            expect_out($sformatf("rr%0d_load", k), 0, w, prev_q, prev_o, 1'b1, 1'b1);
            step();
            prev_q = dv[k % 3]; prev_o = 2'(k % 3);
            expect_out($sformatf("rr%0d_hold1", k), 0, w, prev_q, prev_o, 1'b1, 1'b0);
            step();
            expect_out($sformatf("rr%0d_hold2", k), 0, w, prev_q, prev_o, 1'b1, 1'b0);
            step();
            expect_out($sformatf("rr%0d_idle", k), 0, 3'b000, prev_q, prev_o, 1'b0, 1'b0);
            step();
        end

        // Withdrawal during LOAD and data change during HOLD.
        req = 3'b001; d0 = 4'b0011;
        expect_out("wd_load", 0, 3'b001, 4'b0001, 2'd0, 1'b1, 1'b1);
        step();
        req = 3'b000;
        expect_out("wd_hold1", 0, 3'b001, 4'b0011, 2'd0, 1'b1, 1'b0);
        step();
        d0 = 4'b1111;
        expect_out("wd_hold2", 0, 3'b001, 4'b0011, 2'd0, 1'b1, 1'b0);
        step();
        expect_out("wd_idle", 0, 3'b000, 4'b0011, 2'd0, 1'b0, 1'b0);
        step();
        expect_out("wd_idle2", 0, 3'b000, 4'b0011, 2'd0, 1'b0, 1'b0);
        step();

        // Reset during LOAD aborts the load and restores requester-0 priority.
        req = 3'b010; d1 = 4'b0101;
        expect_out("rst_mid_load", 0, 3'b010, 4'b0011, 2'd0, 1'b1, 1'b1);
        step();
        reset = 1'b1;
        expect_out("rst_mid_abort", 0, 3'b000, 4'b0000, 2'd0, 1'b0, 1'b0);
        step();
        reset = 1'b0; req = 3'b111;
        expect_out("rst_mid_regrant", 0, 3'b001, 4'b0000, 2'd0, 1'b1, 1'b1);
        step();
        req = 3'b000; d0 = 4'b1001;
        expect_out("rst_mid_q", 0, 3'b001, 4'b1001, 2'd0, 1'b1, 1'b0);
        step();

        // HOLD_CYC = 0 instance: requester 2 held, grant toggles every cycle.
        reset = 1'b1;
        expect_out("h0_reset", 1, 3'b000, 4'b0000, 2'd0, 1'b0, 1'b0);
        step();
        reset = 1'b0; req = 3'b100;
        prev_q = 4'b0000; prev_o = 2'd0;
        for (int k = 0; k < 3; k++) begin
            d2 = 4'(4'b0111 + k * 3);
            expect_out($sformatf("h0_%0d_load", k), 1, 3'b100, prev_q, prev_o, 1'b1, 1'b1);
            step();
            prev_q = 4'(4'b0111 + k * 3); prev_o = 2'd2;
            expect_out($sformatf("h0_%0d_idle", k), 1, 3'b000, prev_q, prev_o, 1'b0, 1'b0);
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
        $finish;
    end

endmodule
